// File: rtl/mem_pkg.sv
// Shared memory-side types and constants for the responder and future cache logic.
package mem_pkg;

  localparam int unsigned WORD_W              = 16;
  localparam int unsigned ADDR_W              = 16;
  localparam int unsigned DEFAULT_MEM_LATENCY = 4;

  // Request as seen on the CPU memory port.
  typedef struct packed {
    logic              enable;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data_in;
  } mem_req_t;

  // Payload carried through the read pipeline.
  typedef struct packed {
    logic              err;
    logic [WORD_W-1:0] data;
  } mem_rsp_t;

  // Byte address with the low bit set is not word aligned.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU memory request/response bus; master is the initiator, slave the responder.
interface mem_responder_if;

  logic                       enable;
  logic                       wr;
  logic [mem_pkg::ADDR_W-1:0] addr;
  logic [mem_pkg::WORD_W-1:0] data_in;
  logic [mem_pkg::WORD_W-1:0] data_out;
  logic                       data_valid;
  logic                       busy;
  logic                       err;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, busy, err
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, busy, err
  );

endinterface

// File: rtl/delay_line.sv
// DEPTH-stage register chain with a valid bit per stage. Payload of an empty
// stage is held at zero so the tail output reads zero whenever it is invalid.
module delay_line #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             any_valid
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];

  // Next stage contents: load stage 0, shift the rest by one.
  always_comb begin
    valid_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      data_d[i] = '0;
    end
    valid_d[0] = in_valid;
    data_d[0]  = in_valid ? in_data : '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  // Stage registers; reset empties every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign any_valid = |valid_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency pipelined word memory responding to the CPU memory port.
// Reads snapshot the array at acceptance and emerge LATENCY cycles later
// (LATENCY legal range 1..8). Optional misaligned-access checking is
// enabled by defining MEM_MISALIGN_ERR_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned LATENCY   = DEFAULT_MEM_LATENCY,
  parameter int unsigned ADDR_BITS = 13
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int unsigned DEPTH_WORDS = 1 << ADDR_BITS;
  localparam int unsigned RSP_W       = $bits(mem_rsp_t);

  mem_req_t               req_c;
  mem_rsp_t               rsp_in_c;
  mem_rsp_t               rsp_out_c;
  logic [ADDR_BITS-1:0]   idx_c;
  logic                   rd_fire_c;
  logic                   wr_fire_c;
  logic                   rd_err_c;
  logic                   wr_ok_c;
  logic                   out_valid_c;
  logic                   any_valid_c;
  logic [RSP_W-1:0]       out_data_c;
  logic                   unused_addr_c;
  logic [WORD_W-1:0]      mem_q [DEPTH_WORDS];

  // Gather the request and decode it into read/write strobes and a word index.
  always_comb begin
    req_c.enable  = bus.enable;
    req_c.wr      = bus.wr;
    req_c.addr    = bus.addr;
    req_c.data_in = bus.data_in;

    idx_c = req_c.addr[ADDR_BITS:1];
`ifdef MEM_MISALIGN_ERR_EN
    rd_err_c = is_misaligned(req_c.addr);
    wr_ok_c  = ~is_misaligned(req_c.addr);
`else
    rd_err_c = 1'b0;
    wr_ok_c  = 1'b1;
`endif
    rd_fire_c = req_c.enable & ~req_c.wr;
    wr_fire_c = req_c.enable &  req_c.wr & wr_ok_c;

    rsp_in_c.err  = rd_err_c;
    rsp_in_c.data = mem_q[idx_c];
  end

  // Address bits above the index (and addr[0] when unchecked) are ignored.
  assign unused_addr_c = ^req_c.addr;

  // Storage array; not reset, contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_fire_c) begin
      mem_q[idx_c] <= req_c.data_in;
    end
  end

  // Read pipeline carrying {err, data} with a valid bit per stage.
  delay_line #(
    .DEPTH (LATENCY),
    .WIDTH (RSP_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_fire_c),
    .in_data   (rsp_in_c),
    .out_valid (out_valid_c),
    .out_data  (out_data_c),
    .any_valid (any_valid_c)
  );

  assign rsp_out_c      = out_data_c;
  assign bus.data_valid = out_valid_c;
  assign bus.data_out   = rsp_out_c.data;
  assign bus.err        = rsp_out_c.err;
  assign bus.busy       = any_valid_c;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, latency, streaming, snapshot,
// reset mid-flight, address wrap and misalignment handling.
module tb_mem_responder;

  localparam int unsigned LAT = 4;

`ifdef MEM_MISALIGN_ERR_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  mem_responder_if bus();

  mem_responder #(
    .LATENCY   (LAT),
    .ADDR_BITS (13)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic chk_rsp(input string tag, input logic dv, input logic [15:0] d, input logic e);
    chk({tag, ".dv"},   32'(bus.data_valid), 32'(dv));
    chk({tag, ".data"}, 32'(bus.data_out),   32'(d));
    chk({tag, ".err"},  32'(bus.err),        32'(e));
  endtask

  task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.enable  = en;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b0;
    idle();

    // Reset: outputs clear immediately, stay clear through and after reset.
    #2 rst = 1'b1;
    #1;
    chk_rsp("rst_now", 1'b0, 16'h0000, 1'b0);
    chk("rst_now.busy", 32'(bus.busy), 32'd0);
    step();
    step();
    chk_rsp("rst_hold", 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_rsp("rst_rel", 1'b0, 16'h0000, 1'b0);
    chk("rst_rel.busy", 32'(bus.busy), 32'd0);

    // Latency: write then read 0x0010, data after LAT edges.
    drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step();
    chk("lat_wr.busy", 32'(bus.busy), 32'd0);
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    step();
    idle();
    chk("lat_e1.busy", 32'(bus.busy), 32'd1);
    chk_rsp("lat_e1", 1'b0, 16'h0000, 1'b0);
    step();
    chk_rsp("lat_e2", 1'b0, 16'h0000, 1'b0);
    step();
    chk_rsp("lat_e3", 1'b0, 16'h0000, 1'b0);
    chk("lat_e3.busy", 32'(bus.busy), 32'd1);
    step();
    chk_rsp("lat_e4", 1'b1, 16'hBEEF, 1'b0);
    chk("lat_e4.busy", 32'(bus.busy), 32'd1);
    step();
    chk_rsp("lat_e5", 1'b0, 16'h0000, 1'b0);
    chk("lat_e5.busy", 32'(bus.busy), 32'd0);

    // Streaming: preload 8 words, 8 back-to-back reads, no bubbles.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 16'(2 * i), 16'(16'h1000 + i));
      step();
    end
    for (int k = 0; k < 8 + int'(LAT) + 1; k++) begin
      int j;
      if (k < 8) drive(1'b1, 1'b0, 16'(2 * k), 16'h0000);
      else       idle();
      step();
      j = k - (int'(LAT) - 1);
      if (j >= 0 && j < 8) chk_rsp($sformatf("strm%0d", k), 1'b1, 16'(16'h1000 + j), 1'b0);
      else                 chk_rsp($sformatf("strm%0d", k), 1'b0, 16'h0000, 1'b0);
    end
    chk("strm_end.busy", 32'(bus.busy), 32'd0);

    // Snapshot: a later write does not affect an in-flight read.
    drive(1'b1, 1'b1, 16'h0020, 16'h1111);
    step();
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    step();
    drive(1'b1, 1'b1, 16'h0020, 16'h2222);
    step();
    drive(1'b1, 1'b0, 16'h0020, 16'h0000);
    step();
    idle();
    chk_rsp("snap_a2", 1'b0, 16'h0000, 1'b0);
    step();
    chk_rsp("snap_old", 1'b1, 16'h1111, 1'b0);
    step();
    chk_rsp("snap_gap", 1'b0, 16'h0000, 1'b0);
    step();
    chk_rsp("snap_new", 1'b1, 16'h2222, 1'b0);
    step();
    chk_rsp("snap_end", 1'b0, 16'h0000, 1'b0);
    chk("snap_end.busy", 32'(bus.busy), 32'd0);

    // Reset mid-flight: in-flight reads are dropped, array survives.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 16'(2 * i), 16'h0000);
      step();
    end
    idle();
    chk("mid_pre.busy", 32'(bus.busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk_rsp("mid_rst", 1'b0, 16'h0000, 1'b0);
    chk("mid_rst.busy", 32'(bus.busy), 32'd0);
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("mid_quiet%0d.dv", k), 32'(bus.data_valid), 32'd0);
      chk($sformatf("mid_quiet%0d.busy", k), 32'(bus.busy), 32'd0);
    end
    for (int k = 0; k < 3 + int'(LAT); k++) begin
      int j;
      if (k < 3) drive(1'b1, 1'b0, 16'(2 * k), 16'h0000);
      else       idle();
      step();
      j = k - (int'(LAT) - 1);
      if (j >= 0 && j < 3) chk_rsp($sformatf("mid_rb%0d", k), 1'b1, 16'(16'h1000 + j), 1'b0);
      else                 chk_rsp($sformatf("mid_rb%0d", k), 1'b0, 16'h0000, 1'b0);
    end

    // Wrap and misalignment: 0x4010 aliases 0x0010 with 13 index bits.
    drive(1'b1, 1'b1, 16'h4010, 16'hCAFE);
    step();
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    step();
    drive(1'b1, 1'b0, 16'h0011, 16'h0000);
    step();
    drive(1'b1, 1'b1, 16'h0011, 16'h1234);
    step();
    drive(1'b1, 1'b0, 16'h0010, 16'h0000);
    step();
    idle();
    chk_rsp("wrap_rd", 1'b1, 16'hCAFE, 1'b0);
    step();
    chk_rsp("mis_rd", 1'b1, 16'hCAFE, MIS_EN);
    step();
    chk_rsp("mis_gap", 1'b0, 16'h0000, 1'b0);
    step();
    chk_rsp("mis_wr", 1'b1, MIS_EN ? 16'hCAFE : 16'h1234, 1'b0);
    step();
    chk_rsp("mis_end", 1'b0, 16'h0000, 1'b0);
    chk("mis_end.busy", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
